// File: rtl/mix_column_pkg.sv
// Shared GF(2^8) helpers, coefficient tables and mode encoding for the MixColumns block.
package mix_column_pkg;

    localparam logic [7:0] GF_REDUCE = 8'h1B;

    localparam logic [7:0] FWD_COEF [0:3] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_COEF [0:3] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_REDUCE : 8'h00);
    endfunction

    // Shift-and-add multiply; with constant coefficients only the set bits survive synthesis.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_column_byte.sv
// One output byte of MixColumns from the four rotated input bytes.
// Inverse datapath present only when MIX_COLUMN_INV_EN is defined.
module mix_column_byte
    import mix_column_pkg::*;
(
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    input  mode_e      mode,
    output logic [7:0] b
);

    logic [7:0] fwd;

    always_comb begin
        fwd = gf_mul(s0, FWD_COEF[0]) ^ gf_mul(s1, FWD_COEF[1])
            ^ gf_mul(s2, FWD_COEF[2]) ^ gf_mul(s3, FWD_COEF[3]);
    end

`ifdef MIX_COLUMN_INV_EN
    logic [7:0] inv;

    always_comb begin
        inv = gf_mul(s0, INV_COEF[0]) ^ gf_mul(s1, INV_COEF[1])
            ^ gf_mul(s2, INV_COEF[2]) ^ gf_mul(s3, INV_COEF[3]);
        b = (mode == MODE_DEC) ? inv : fwd;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        b = fwd;
    end
`endif

endmodule

// File: rtl/mix_column.sv
// AES MixColumns / InvMixColumns on one 32-bit column, one-cycle registered latency.
// Define MIX_COLUMN_INV_EN to enable the inverse mode selected by enc_dec.
module mix_column
    import mix_column_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic        enc_dec,
    output logic        out_valid,
    output logic [31:0] B
);

    logic [7:0] s [0:3];
    logic [7:0] r [0:3];
    mode_e      mode;

    assign s[0] = A[31:24];
    assign s[1] = A[23:16];
    assign s[2] = A[15:8];
    assign s[3] = A[7:0];
    assign mode = mode_e'(enc_dec);

    // Row k sees the column rotated up by k bytes.
    mix_column_byte u_row0 (.s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .mode(mode), .b(r[0]));
    mix_column_byte u_row1 (.s0(s[1]), .s1(s[2]), .s2(s[3]), .s3(s[0]), .mode(mode), .b(r[1]));
    mix_column_byte u_row2 (.s0(s[2]), .s1(s[3]), .s2(s[0]), .s3(s[1]), .mode(mode), .b(r[2]));
    mix_column_byte u_row3 (.s0(s[3]), .s1(s[0]), .s2(s[1]), .s3(s[2]), .mode(mode), .b(r[3]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            B         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) B <= {r[0], r[1], r[2], r[3]};
        end
    end

endmodule

// File: tb/tb_mix_column.sv
// Scoreboard bench for mix_column; expectations follow MIX_COLUMN_INV_EN if defined.
module tb_mix_column;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic        enc_dec;
    logic        out_valid;
    logic [31:0] B;

    int compared;
    int mismatched;
    logic [31:0] sb [$];
    logic [31:0] held;

    mix_column dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A),
        .enc_dec(enc_dec), .out_valid(out_valid), .B(B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial-product reference, reduced by long division with 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] a, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
        logic [7:0] s [4];
        logic [31:0] res;
        s[0] = a[31:24]; s[1] = a[23:16]; s[2] = a[15:8]; s[3] = a[7:0];
        res = 32'h0;
        for (int r = 0; r < 4; r++)
            res[31 - 8*r -: 8] = ref_mul(s[r], c0) ^ ref_mul(s[(r+1)%4], c1)
                               ^ ref_mul(s[(r+2)%4], c2) ^ ref_mul(s[(r+3)%4], c3);
        return res;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [31:0] a);
        return ref_mix(a, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    function automatic logic [31:0] ref_inv(input logic [31:0] a);
        return ref_mix(a, 8'h0E, 8'h0B, 8'h0D, 8'h09);
    endfunction

    // exp is the value for the build with the inverse enabled; forward-only builds
    // must return the forward result regardless of enc_dec.
    task automatic issue(input logic [31:0] a, input logic dec, input logic [31:0] exp);
        @(negedge clk);
        A        = a;
        enc_dec  = dec;
        in_valid = 1'b1;
`ifdef MIX_COLUMN_INV_EN
        sb.push_back(exp);
`else
        sb.push_back(dec ? ref_fwd(a) : exp);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = $urandom;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per valid output, otherwise checks B is held.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("out_valid", {31'h0, out_valid}, {31'h0, (sb.size() > 0)});
                if (out_valid && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("B_result", B, e);
                    held = e;
                end else if (!out_valid) begin
                    check("B_hold", B, held);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rf;
        compared   = 0;
        mismatched = 0;
        held       = 32'h0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = 32'h0;
        enc_dec    = 1'b0;
        #2;
        check("reset_B", B, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        issue(32'hd4bf5d30, 1'b0, 32'h046681e5);
        idle(1);
        issue(32'h046681e5, 1'b1, 32'hd4bf5d30);
        idle(1);
        issue(32'hdb135345, 1'b0, 32'h8e4da1bc);
        issue(32'h8e4da1bc, 1'b1, 32'hdb135345);
        issue(32'h01010101, 1'b0, 32'h01010101);
        issue(32'h01010101, 1'b1, 32'h01010101);
        issue(32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6);
        issue(32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6);
        issue(32'hf20a225c, 1'b0, 32'h9fdc589d);
        issue(32'h9fdc589d, 1'b1, 32'hf20a225c);
        issue(32'h2d26314c, 1'b0, 32'h4d7ebdf8);
        issue(32'h4d7ebdf8, 1'b1, 32'h2d26314c);
        idle(2);

        // Back-to-back mixed modes, then idle so B must hold.
        issue(32'hd4bf5d30, 1'b0, 32'h046681e5);
        issue(32'h046681e5, 1'b1, 32'hd4bf5d30);
        idle(3);

        // Mid-stream reset while out_valid is high; inputs seen during reset are discarded.
        issue(32'hdb135345, 1'b0, 32'h8e4da1bc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        held = 32'h0;
        #1;
        check("midreset_B", B, 32'h0);
        check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        A        = 32'h12345678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rf = ref_fwd(ra);
            issue(ra, 1'b0, rf);
            issue(rf, 1'b1, ra);
            if (ref_inv(rf) !== ra) begin
                compared++;
                mismatched++;
                $display("FAIL ref_roundtrip: got %08h expected %08h", ref_inv(rf), ra);
            end
        end
        idle(3);
        check("scoreboard_empty", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mix_column.md
MIX_COLUMN -- requirements
Module: mix_column

Interface
REQ-001 SHALL have no parameters; the column width is fixed at 32 bits (4 bytes).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: A and enc_dec are sampled when high.
REQ-005 SHALL have port A, input, 32 bits: state column; A[31:24]=s0 (row 0) ... A[7:0]=s3 (row 3).
REQ-006 SHALL have port enc_dec, input, 1 bit: 0 = forward MixColumns (encrypt), 1 = InvMixColumns (decrypt).
REQ-007 SHALL have port out_valid, output, 1 bit: B holds a new result.
REQ-008 SHALL have port B, output, 32 bits: result column, same byte order as A.

Function
REQ-009 SHALL treat each byte as an element of GF(2^8) with reduction polynomial 0x11B.
REQ-010 SHALL implement xtime(x) as (x<<1) XOR (0x1B if x[7]=1), truncated to 8 bits.
REQ-011 Forward mode SHALL compute row r of B as 02*s[r] ^ 03*s[r+1] ^ 01*s[r+2] ^ 01*s[r+3], indices mod 4.
REQ-012 Inverse mode SHALL compute row r of B as 0E*s[r] ^ 0B*s[r+1] ^ 0D*s[r+2] ^ 09*s[r+3], indices mod 4.
REQ-013 Latency SHALL be exactly 1 cycle: when in_valid is high at edge N, B holds the result and out_valid=1 after edge N.
REQ-014 When in_valid is low at an edge, out_valid SHALL be 0 after that edge and B SHALL hold its previous value.
REQ-015 SHALL accept a new column every cycle with no backpressure; back-to-back inputs of mixed modes SHALL each produce their own correct result.
REQ-016 The combinational datapath SHALL be free of latches and SHALL produce no X on B for any known A.
REQ-017 For every A, the inverse result of the forward result SHALL equal A.

Reset
REQ-018 When rst_n is low, B SHALL be 32'h00000000 and out_valid SHALL be 0, immediately and independent of clk.
REQ-019 Reset asserted mid-stream SHALL discard any pending result; the first valid output after release SHALL come only from an input sampled after release.
REQ-020 Reset deassertion SHALL be synchronized to clk externally; the block SHALL not filter it.

Configuration
REQ-021 Macro MIX_COLUMN_INV_EN SHALL control the inverse datapath.
REQ-022 With MIX_COLUMN_INV_EN defined, enc_dec SHALL select the mode as in REQ-006.
REQ-023 Without MIX_COLUMN_INV_EN, the inverse logic SHALL be omitted, enc_dec SHALL be ignored, and the block SHALL always compute forward mode.

Structure
REQ-024 Package mix_column_pkg SHALL hold the xtime and gf_mul functions, the 0x1B reduction constant, the forward coefficients {02,03,01,01}, the inverse coefficients {0E,0B,0D,09}, and the mode enum (MODE_ENC=0, MODE_DEC=1).
REQ-025 Sub-module mix_column_byte SHALL compute one output byte from four input bytes and the mode; mix_column SHALL instantiate it four times with rotated inputs and register the outputs.

Verification
REQ-026 Forward: A=d4bf5d30, enc_dec=0 -> B=046681e5 one cycle later, with out_valid=1.
REQ-027 Inverse: A=046681e5, enc_dec=1 -> B=d4bf5d30.
REQ-028 Vectors: A=db135345 fwd -> 8e4da1bc; A=8e4da1bc inv -> db135345; A=01010101 or c6c6c6c6 -> unchanged in both modes.
REQ-029 Back-to-back: d4bf5d30/enc, then 046681e5/dec, then in_valid=0 -> B sequence 046681e5, d4bf5d30, then held, with out_valid 1,1,0.
REQ-030 Reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> B=0 and out_valid=0 immediately; no stale output after release.
REQ-031 Random: 1000 random A values -> fwd then inv returns A; results match a reference model; repeat with MIX_COLUMN_INV_EN undefined, where enc_dec=1 still yields the forward result.
